// File: rtl/uart_rx_byte.sv
// 8N1 (or 8E1 with UART_RX_PARITY_EN) UART receiver with mid-bit sampling.
// The received byte goes to a single-entry valid/ready holding register. Errors are reported as one-cycle strobes.
module uart_rx_byte #(
    parameter int BIT_CLKS    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW = (BIT_CLKS > 2) ? $clog2(BIT_CLKS) : 1;
    localparam logic [CW-1:0] HALF = CW'(BIT_CLKS / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(BIT_CLKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] fill_q, fill_d;
    logic                   armed_q, armed_d;
    logic                   rxs_prev_q, rxs_prev_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   done_good;
    logic                   rxs;
`ifdef UART_RX_PARITY_EN
    logic                   par_bad_q, par_bad_d;
    logic                   parity_err_q, parity_err_d;
`endif

    assign rxs = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], rx_in};
        fill_d      = {fill_q[SYNC_STAGES-2:0], 1'b1};
        // Only a high level that really came through the synchronizer arms start
        // detection, so a line already low at reset release is ignored.
        armed_d     = armed_q | (fill_q[SYNC_STAGES-1] & rxs);
        rxs_prev_d  = rxs;
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        done_good   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif

        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (armed_q && rxs_prev_q && !rxs) begin
                    cnt_d   = HALF;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                else if (rxs) state_d = S_IDLE;
                else begin
                    cnt_d   = FULL;
                    idx_d   = 3'd0;
                    state_d = S_DATA;
`ifdef UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end
            end
            S_DATA: begin
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                else begin
                    shift_d[idx_q] = rxs;
                    cnt_d          = FULL;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                else begin
                    par_bad_d = ^{shift_q, rxs};
                    cnt_d     = FULL;
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                else if (!rxs) begin
                    frame_err_d = 1'b1;
                    state_d     = S_BREAK;
                end else begin
                    state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                    if (par_bad_q) parity_err_d = 1'b1;
                    else done_good = 1'b1;
`else
                    done_good = 1'b1;
`endif
                end
            end
            S_BREAK: begin
                if (rxs) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (done_good) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            sync_q      <= '1;
            fill_q      <= '0;
            armed_q     <= 1'b0;
            rxs_prev_q  <= 1'b1;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            fill_q      <= fill_d;
            armed_q     <= armed_d;
            rxs_prev_q  <= rxs_prev_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
